// File: rtl/dp_pkg.sv
// dp_pkg: shared types and helpers for the bus_datapath_seq slice.
// Optional feature macro: DP_MUL_EN (makes MUL legal and enables HI/LO).
package dp_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_SHRA = 4'd6,
        OP_NOT  = 4'd7,
        OP_NEG  = 4'd8,
        OP_MUL  = 4'd9
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TA   = 3'd1,
        ST_TB   = 3'd2,
        ST_TW   = 3'd3,
        ST_TH   = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

`ifdef DP_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    // Codes 0-8 are always legal; 9 (MUL) only when the multiplier is built.
    function automatic logic is_legal(input logic [OP_W-1:0] op);
        logic legal_s;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL,
            OP_SHR, OP_SHRA, OP_NOT, OP_NEG: legal_s = 1'b1;
            OP_MUL:                          legal_s = MUL_EN;
            default:                         legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU of the single-bus datapath.
// zlow carries the DATA_W result; zhigh is the upper half of a MUL product
// (built only when DP_MUL_EN is defined, otherwise constant 0).
module dp_alu
    import dp_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] zhigh,
    output logic [DATA_W-1:0] zlow
);

    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh_amt_s;

    // Only the low bits of B select the shift distance.
    assign sh_amt_s = b[SH_W-1:0];

`ifdef DP_MUL_EN
    logic signed [2*DATA_W-1:0] a_ext_s;
    logic signed [2*DATA_W-1:0] b_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;

    assign a_ext_s = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext_s = {{DATA_W{b[DATA_W-1]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;
`endif

    // Operation decode; unary ops ignore b entirely.
    always_comb begin
        zhigh = '0;
        zlow  = '0;
        case (op)
            OP_ADD:  zlow = a + b;
            OP_SUB:  zlow = a - b;
            OP_AND:  zlow = a & b;
            OP_OR:   zlow = a | b;
            OP_SHL:  zlow = a << sh_amt_s;
            OP_SHR:  zlow = a >> sh_amt_s;
            OP_SHRA: zlow = $signed(a) >>> sh_amt_s;
            OP_NOT:  zlow = ~a;
            OP_NEG:  zlow = '0 - a;
`ifdef DP_MUL_EN
            OP_MUL: begin
                zhigh = prod_s[2*DATA_W-1:DATA_W];
                zlow  = prod_s[DATA_W-1:0];
            end
`endif
            default: zlow = '0;
        endcase
    end

endmodule

// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq: register file, Y/Z/HI/LO staging, single internal bus and
// ALU, sequenced by an internal micro-sequencer (IDLE/TA/TB/TW/TH/ERR).
// Optional feature macro: DP_MUL_EN (MUL op, TH state and HI/LO writes).
module bus_datapath_seq
    import dp_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    parameter  int R0_ZERO  = 1,
    localparam int AW       = $clog2(NUM_REGS)
)(
    input  logic              Clock,
    input  logic              clear,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    input  logic [AW-1:0]     rd,
    input  logic              imm_sel,
    input  logic [DATA_W-1:0] imm,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              z_flag,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [DATA_W-1:0] bus_out
);

    localparam logic R0_HARD = (R0_ZERO != 0);

    state_e              state_r, state_nx_s;
    logic [OP_W-1:0]     op_r;
    logic [AW-1:0]       ra_r, rb_r, rd_r;
    logic [DATA_W-1:0]   imm_r;
    logic                imm_sel_r;

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic [DATA_W-1:0]   y_r, zhigh_r, zlow_r, hi_r, lo_r;
    logic                done_r, err_r, z_flag_r;

    logic [DATA_W-1:0]   bus_s, ra_val_s, rb_val_s;
    logic [DATA_W-1:0]   alu_zhigh_s, alu_zlow_s;
    logic                is_mul_s, idle_s;
    logic                y_ld_s, z_ld_s, rf_wr_s, lo_ld_s, hi_ld_s, fin_s, zf_nx_s;

    assign idle_s   = (state_r == ST_IDLE);
    assign is_mul_s = MUL_EN && (op_r == OP_MUL);

    // R0 reads as zero when hard-wired, independent of array contents.
    assign ra_val_s = (R0_HARD && ra_r == '0)     ? '0 : regs_r[ra_r];
    assign rb_val_s = (R0_HARD && rb_r == '0)     ? '0 : regs_r[rb_r];
    assign dbg_data = (R0_HARD && dbg_addr == '0) ? '0 : regs_r[dbg_addr];

    assign busy    = ~idle_s;
    assign done    = done_r;
    assign err     = err_r;
    assign z_flag  = z_flag_r;
    assign hi_out  = hi_r;
    assign lo_out  = lo_r;
    assign bus_out = bus_s;

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (op_r),
        .a     (y_r),
        .b     (bus_s),
        .zhigh (alu_zhigh_s),
        .zlow  (alu_zlow_s)
    );

    // Sequencer state register.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Sequencer next-state logic; illegal ops detour through ERR.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (is_legal(op)) begin
                        state_nx_s = ST_TA;
                    end else begin
                        state_nx_s = ST_ERR;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_TA:   state_nx_s = ST_TB;
            ST_TB:   state_nx_s = ST_TW;
            ST_TW: begin
                if (is_mul_s) begin
                    state_nx_s = ST_TH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_TH:   state_nx_s = ST_IDLE;
            ST_ERR:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Sequencer outputs: bus source and register load strobes per state.
    always_comb begin
        bus_s   = '0;
        y_ld_s  = 1'b0;
        z_ld_s  = 1'b0;
        rf_wr_s = 1'b0;
        lo_ld_s = 1'b0;
        hi_ld_s = 1'b0;
        fin_s   = 1'b0;
        zf_nx_s = 1'b0;
        case (state_r)
            ST_TA: begin
                bus_s  = ra_val_s;
                y_ld_s = 1'b1;
            end
            ST_TB: begin
                bus_s  = imm_sel_r ? imm_r : rb_val_s;
                z_ld_s = 1'b1;
            end
            ST_TW: begin
                bus_s = zlow_r;
                if (is_mul_s) begin
                    lo_ld_s = 1'b1;
                end else begin
                    rf_wr_s = 1'b1;
                    fin_s   = 1'b1;
                    zf_nx_s = (zlow_r == '0);
                end
            end
            ST_TH: begin
                bus_s   = zhigh_r;
                hi_ld_s = 1'b1;
                fin_s   = 1'b1;
                zf_nx_s = ({zhigh_r, zlow_r} == '0);
            end
            ST_IDLE, ST_ERR: bus_s = '0;
            default:         bus_s = '0;
        endcase
    end

    // Operand capture at acceptance so later input changes cannot disturb the op.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            op_r      <= '0;
            ra_r      <= '0;
            rb_r      <= '0;
            rd_r      <= '0;
            imm_r     <= '0;
            imm_sel_r <= 1'b0;
        end else if (idle_s && start) begin
            op_r      <= op;
            ra_r      <= ra;
            rb_r      <= rb;
            rd_r      <= rd;
            imm_r     <= imm;
            imm_sel_r <= imm_sel;
        end
    end

    // Register file: sequencer writeback in TW, external load only while idle.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (rf_wr_s && !(R0_HARD && rd_r == '0)) begin
                regs_r[rd_r] <= bus_s;
            end
            if (ld_en && idle_s && !(R0_HARD && ld_addr == '0)) begin
                regs_r[ld_addr] <= ld_data;
            end
        end
    end

    // Y/Z staging registers and completion status.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            y_r      <= '0;
            zhigh_r  <= '0;
            zlow_r   <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            z_flag_r <= 1'b0;
        end else begin
            if (y_ld_s) begin
                y_r <= bus_s;
            end
            if (z_ld_s) begin
                zhigh_r <= alu_zhigh_s;
                zlow_r  <= alu_zlow_s;
            end
            done_r <= fin_s;
            err_r  <= (state_r == ST_ERR);
            if (fin_s) begin
                z_flag_r <= zf_nx_s;
            end
        end
    end

    // HI/LO capture; strobes never fire when the multiplier is not built.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            if (lo_ld_s) begin
                lo_r <= bus_s;
            end
            if (hi_ld_s) begin
                hi_r <= bus_s;
            end
        end
    end

endmodule

// File: tb/tb_bus_datapath_seq.sv
// tb_bus_datapath_seq: self-checking bench for bus_datapath_seq with a
// scoreboard queue of expected writebacks. Honours DP_MUL_EN if defined.
module tb_bus_datapath_seq;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] val;
        logic        zf;
    } exp_t;

    logic        clk;
    logic        clear;
    logic        start;
    logic [3:0]  op;
    logic [3:0]  ra, rb, rd;
    logic        imm_sel;
    logic [31:0] imm;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        busy, done, err, z_flag;
    logic [31:0] hi_out, lo_out, bus_out;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1)) dut (
        .Clock    (clk),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .ra       (ra),
        .rb       (rb),
        .rd       (rd),
        .imm_sel  (imm_sel),
        .imm      (imm),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .z_flag   (z_flag),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .bus_out  (bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU for the non-MUL ops.
    function automatic logic [31:0] model_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (o)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a << s;
            4'd5:    return a >> s;
            4'd6:    return $signed(a) >>> s;
            4'd7:    return ~a;
            4'd8:    return 32'd0 - a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ld(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] d, input logic isel, input logic [31:0] im);
        @(negedge clk);
        op = o; ra = a; rb = b; rd = d; imm_sel = isel; imm = im; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns the edge index (relative to the accept edge) where the pulse shows, or -1.
    task automatic wait_pulse(input logic want_err, input int n0, output int lat);
        int n;
        n   = n0;
        lat = -1;
        while (n < 20) begin
            @(posedge clk); n++; #1;
            if (want_err ? err : done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic peek(input logic [3:0] a, output logic [31:0] v);
        dbg_addr = a; #1;
        v = dbg_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear = 1'b0; start = 1'b0; op = 4'd0; ra = 4'd0; rb = 4'd0; rd = 4'd0;
        imm_sel = 1'b0; imm = 32'd0; ld_en = 1'b0; ld_addr = 4'd0; ld_data = 32'd0; dbg_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if ({done, err, z_flag} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {done, err, z_flag}); end
        total++; if ({hi_out, lo_out, bus_out} !== 96'd0) begin bad++; $display("FAIL reset_hilobus got=%h/%h/%h exp=0", hi_out, lo_out, bus_out); end
        peek(4'd1, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_reg got=%h exp=0", v); end
        @(negedge clk);
        clear = 1'b1;
    endtask

    task automatic test_add();
        int lat; exp_t e; logic [31:0] v;
        ld(4'd1, 32'd5);
        ld(4'd2, 32'd7);
        sb_q.push_back('{rd: 4'd3, val: 32'd12, zf: 1'b0});
        issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
        total++; if (bus_out !== 32'd5) begin bad++; $display("FAIL add_ta_bus got=%h exp=5", bus_out); end
        peek(4'd3, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL add_pre_write got=%h exp=0", v); end
        wait_pulse(1'b0, 0, lat);
        e = sb_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL add_latency got=%0d exp=3", lat); end
        peek(e.rd, v);
        total++; if (v !== e.val) begin bad++; $display("FAIL add_value got=%h exp=%h", v, e.val); end
        total++; if (z_flag !== e.zf) begin bad++; $display("FAIL add_zflag got=%b exp=%b", z_flag, e.zf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_at_done got=%b exp=0", busy); end
    endtask

    task automatic test_sub_shift();
        int lat; exp_t e; logic [31:0] v;
        ld(4'd5, 32'h8000_0000);
        sb_q.push_back('{rd: 4'd4, val: 32'd0,          zf: 1'b1});
        sb_q.push_back('{rd: 4'd6, val: 32'hF800_0000,  zf: 1'b0});
        sb_q.push_back('{rd: 4'd7, val: 32'd10,         zf: 1'b0});
        sb_q.push_back('{rd: 4'd8, val: 32'h0800_0000,  zf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       issue(4'd1, 4'd1, 4'd1, 4'd4, 1'b0, 32'd0);
                1:       issue(4'd6, 4'd5, 4'd0, 4'd6, 1'b1, 32'd4);
                2:       issue(4'd4, 4'd1, 4'd0, 4'd7, 1'b1, 32'd33);
                default: issue(4'd5, 4'd5, 4'd0, 4'd8, 1'b1, 32'd36);
            endcase
            wait_pulse(1'b0, 0, lat);
            e = sb_q.pop_front();
            total++; if (lat !== 3) begin bad++; $display("FAIL subshift_latency[%0d] got=%0d exp=3", i, lat); end
            peek(e.rd, v);
            total++; if (v !== e.val) begin bad++; $display("FAIL subshift_value[%0d] got=%h exp=%h", i, v, e.val); end
            total++; if (z_flag !== e.zf) begin bad++; $display("FAIL subshift_zflag[%0d] got=%b exp=%b", i, z_flag, e.zf); end
        end
    endtask

    task automatic test_random_ops();
        int lat; exp_t e; logic [31:0] v, a, b, im; logic [3:0] o; logic isel;
        for (int i = 0; i < 8; i++) begin
            a    = $urandom;
            b    = (i == 3) ? a : $urandom;
            im   = $urandom;
            o    = (i == 3) ? 4'd1 : 4'($urandom_range(0, 8));
            isel = (i == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            ld(4'd8, a);
            ld(4'd9, b);
            v = model_alu(o, a, isel ? im : b);
            sb_q.push_back('{rd: 4'd15, val: v, zf: (v == 32'd0)});
            issue(o, 4'd8, 4'd9, 4'd15, isel, im);
            wait_pulse(1'b0, 0, lat);
            e = sb_q.pop_front();
            total++; if (lat !== 3) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=3", i, lat); end
            peek(e.rd, v);
            total++; if (v !== e.val) begin bad++; $display("FAIL rand_value[%0d] op=%0d got=%h exp=%h", i, o, v, e.val); end
            total++; if (z_flag !== e.zf) begin bad++; $display("FAIL rand_zflag[%0d] got=%b exp=%b", i, z_flag, e.zf); end
        end
    endtask

    task automatic test_back_to_back();
        int lat; exp_t e; logic [31:0] v; time t0, t1;
        sb_q.push_back('{rd: 4'd12, val: 32'd17, zf: 1'b0});
        issue(4'd0, 4'd3, 4'd1, 4'd12, 1'b0, 32'd0);
        t0 = $time;
        wait_pulse(1'b0, 0, lat);
        e = sb_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=3", lat); end
        peek(e.rd, v);
        total++; if (v !== e.val) begin bad++; $display("FAIL b2b_val1 got=%h exp=%h", v, e.val); end
        sb_q.push_back('{rd: 4'd13, val: 32'd24, zf: 1'b0});
        issue(4'd0, 4'd12, 4'd2, 4'd13, 1'b0, 32'd0);
        t1 = $time;
        total++; if (t1 - t0 !== 40) begin bad++; $display("FAIL b2b_spacing got=%0t exp=40", t1 - t0); end
        wait_pulse(1'b0, 0, lat);
        e = sb_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=3", lat); end
        peek(e.rd, v);
        total++; if (v !== e.val) begin bad++; $display("FAIL b2b_val2 got=%h exp=%h", v, e.val); end
    endtask

    task automatic test_r0_and_ignore();
        int lat; exp_t e; logic [31:0] v;
        sb_q.push_back('{rd: 4'd0, val: 32'd0, zf: 1'b0});
        issue(4'd0, 4'd1, 4'd2, 4'd0, 1'b0, 32'd0);
        wait_pulse(1'b0, 0, lat);
        e = sb_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL r0_done got=%0d exp=3", lat); end
        peek(e.rd, v);
        total++; if (v !== e.val) begin bad++; $display("FAIL r0_value got=%h exp=%h", v, e.val); end
        total++; if (z_flag !== e.zf) begin bad++; $display("FAIL r0_zflag got=%b exp=%b", z_flag, e.zf); end
        // Mid-op start and load must both be ignored; changed inputs must not matter.
        sb_q.push_back('{rd: 4'd11, val: 32'd12, zf: 1'b0});
        issue(4'd0, 4'd1, 4'd2, 4'd11, 1'b0, 32'd0);
        @(negedge clk);
        start = 1'b1; op = 4'd1; ra = 4'd9; rd = 4'd14; ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'd99;
        @(posedge clk); #1;
        start = 1'b0; ld_en = 1'b0;
        wait_pulse(1'b0, 1, lat);
        e = sb_q.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL ign_latency got=%0d exp=3", lat); end
        peek(e.rd, v);
        total++; if (v !== e.val) begin bad++; $display("FAIL ign_value got=%h exp=%h", v, e.val); end
        peek(4'd1, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL ign_load got=%h exp=5", v); end
        repeat (2) @(posedge clk);
        #1;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ign_not_queued got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] v;
        issue(4'd12, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
        wait_pulse(1'b1, 0, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL ill_err_latency got=%0d exp=1", lat); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL ill_busy_done got=%b exp=00", {busy, done}); end
        @(posedge clk); #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_err_pulse got=%b exp=0", err); end
        peek(4'd3, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL ill_no_write got=%h exp=c", v); end
    endtask

    task automatic test_mul();
        int lat; logic [31:0] v;
        ld(4'd1, 32'hFFFF_FFFD);
        ld(4'd2, 32'd4);
        issue(4'd9, 4'd1, 4'd2, 4'd10, 1'b0, 32'd0);
`ifdef DP_MUL_EN
        wait_pulse(1'b0, 0, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL mul_latency got=%0d exp=4", lat); end
        total++; if (lo_out !== 32'hFFFF_FFF4) begin bad++; $display("FAIL mul_lo got=%h exp=fffffff4", lo_out); end
        total++; if (hi_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mul_hi got=%h exp=ffffffff", hi_out); end
        total++; if (z_flag !== 1'b0) begin bad++; $display("FAIL mul_zflag got=%b exp=0", z_flag); end
`else
        wait_pulse(1'b1, 0, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL mul_err_latency got=%0d exp=1", lat); end
        total++; if ({hi_out, lo_out} !== 64'd0) begin bad++; $display("FAIL mul_hilo got=%h/%h exp=0", hi_out, lo_out); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_no_done got=%b exp=0", done); end
`endif
        peek(4'd10, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL mul_rd_untouched got=%h exp=0", v); end
    endtask

    task automatic test_clear_mid();
        int lat; logic [31:0] v;
        ld(4'd1, 32'd5);
        issue(4'd0, 4'd1, 4'd2, 4'd14, 1'b0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk); #1;
        total++; if ({busy, done, err, z_flag} !== 4'b0000) begin bad++; $display("FAIL clr_flags got=%b exp=0000", {busy, done, err, z_flag}); end
        total++; if ({hi_out, lo_out, bus_out} !== 96'd0) begin bad++; $display("FAIL clr_hilobus got=%h/%h/%h exp=0", hi_out, lo_out, bus_out); end
        peek(4'd1, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL clr_reg1 got=%h exp=0", v); end
        @(negedge clk);
        clear = 1'b1;
        wait_pulse(1'b0, 0, lat);
        total++; if (lat !== -1) begin bad++; $display("FAIL clr_no_done got=%0d exp=-1", lat); end
        peek(4'd14, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL clr_no_writeback got=%h exp=0", v); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_shift();
        test_random_ops();
        test_back_to_back();
        test_r0_and_ignore();
        test_illegal();
        test_mul();
        test_clear_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
